// File: rtl/tx_serial_8e1_uc_pkg.sv
// rtl/tx_serial_8e1_uc_pkg.sv - shared state codes and frame constants for the 8E1 transmitter
package tx_serial_8e1_uc_pkg;

  localparam logic [2:0] INICIAL     = 3'b000;
  localparam logic [2:0] PREPARACAO  = 3'b001;
  localparam logic [2:0] ESPERA      = 3'b010;
  localparam logic [2:0] TRANSMISSAO = 3'b011;
  localparam logic [2:0] FINAL       = 3'b100;

  localparam int FRAME_BITS           = 12;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo-M counter with synchronous clear; fim marks the terminal count
module contador_m #(
  parameter int M = 434,
  parameter int N = $clog2(M)
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] TOP = N'(M - 1);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (zera_s) begin
      q_d = '0;
    end else if (conta) begin
      q_d = (q_q == TOP) ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign fim = (q_q == TOP);

endmodule

// File: rtl/tx_serial_8e1_uc.sv
// rtl/tx_serial_8e1_uc.sv - 8E1 transmitter control unit; TX_SERIAL_UC_DEBUG_EN adds db_estado
module tx_serial_8e1_uc
  import tx_serial_8e1_uc_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int TICK_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic       fim,
  output logic       zera,
  output logic       carrega,
  output logic       desloca,
  output logic       conta,
  output logic       pronto,
`ifdef TX_SERIAL_UC_DEBUG_EN
  output logic       ocupado,
  output logic [3:0] db_estado
`else
  output logic       ocupado
`endif
);

  logic [2:0] estado_q;
  logic [2:0] estado_d;
  logic       tick;
  logic       tick_zera;

  // The bit-period counter is held at zero while idle and while loading,
  // so the first bit period always starts fresh from the load cycle.
  assign tick_zera = (estado_q == INICIAL) || (estado_q == PREPARACAO);

  contador_m #(
    .M(CLKS_PER_BIT),
    .N(TICK_W)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .zera_s(tick_zera),
    .conta (1'b1),
    .fim   (tick)
  );

  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:     estado_d = partida ? PREPARACAO : INICIAL;
      PREPARACAO:  estado_d = ESPERA;
      ESPERA:      estado_d = tick ? TRANSMISSAO : ESPERA;
      TRANSMISSAO: estado_d = fim ? FINAL : ESPERA;
      FINAL:       estado_d = INICIAL;
      default:     estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    zera    = 1'b0;
    carrega = 1'b0;
    desloca = 1'b0;
    conta   = 1'b0;
    pronto  = 1'b0;
    ocupado = 1'b0;
    case (estado_q)
      PREPARACAO: begin
        zera    = 1'b1;
        carrega = 1'b1;
        ocupado = 1'b1;
      end
      ESPERA: begin
        ocupado = 1'b1;
      end
      TRANSMISSAO: begin
        desloca = 1'b1;
        conta   = 1'b1;
        ocupado = 1'b1;
      end
      FINAL: begin
        pronto  = 1'b1;
        ocupado = 1'b1;
      end
      default: begin
        ocupado = 1'b0;
      end
    endcase
  end

`ifdef TX_SERIAL_UC_DEBUG_EN
  assign db_estado = {1'b0, estado_q};
`endif

endmodule
